// File: rtl/sync_fifo_burst_reader.sv
// Drain stage behind sync_fifo: pops the show-ahead read port into one registered output slot.
// Latency: first pop one cycle after IDLE sees !fifo_almost_empty; data appears on m_* the edge after its pop.
// Backpressure: a beat waits in the slot while !m_ready; no pop happens until the slot frees.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   fifo_dout/empty/almost_empty  FIFO head entry and flags (almost_empty <=> fewer than BURST_LEN entries)
//   fifo_rd_en            combinational pop strobe; the head is consumed at the same edge
//   m_data/m_valid/m_last/m_ready  registered valid/ready output stream, m_last closes a burst
//   busy                  FSM not idle or a beat is waiting in the slot
//   burst_count           bursts sent (full or single-beat flush), wraps at 16 bits
//   err_underrun          sticky: a burst beat was due while the FIFO was empty
module sync_fifo_burst_reader #(
    parameter int WIDTH     = 32,
    parameter int BURST_LEN = 8,
    parameter int TIMEOUT   = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic             busy,
    output logic [15:0]      burst_count,
    output logic             err_underrun
);

    localparam int BW = $clog2(BURST_LEN);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_LEN - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_cnt_q, beat_cnt_d;
    logic [TW-1:0]    idle_timer_q, idle_timer_d;
    logic [15:0]      burst_count_q, burst_count_d;
    logic             err_underrun_q, err_underrun_d;
    logic [WIDTH-1:0] m_data_q;
    logic             m_valid_q;
    logic             m_last_q;

    logic slot_free;
    logic pop;
    logic pop_last;

    // The slot can take a new beat if it is empty or its beat leaves this edge.
    assign slot_free = !m_valid_q || m_ready;

    always_comb begin
        state_d        = state_q;
        beat_cnt_d     = beat_cnt_q;
        idle_timer_d   = idle_timer_q;
        burst_count_d  = burst_count_q;
        err_underrun_d = err_underrun_q;
        pop            = 1'b0;
        pop_last       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_almost_empty) begin
                    state_d      = ST_BURST;
                    beat_cnt_d   = '0;
                    idle_timer_d = '0;
                end else if (!fifo_empty) begin
                    // Residue below one burst: count idle cycles, flush after TIMEOUT of them.
                    if (idle_timer_q == TIMER_END) begin
                        state_d      = ST_FLUSH;
                        idle_timer_d = '0;
                    end else begin
                        idle_timer_d = idle_timer_q + 1'b1;
                    end
                end else begin
                    idle_timer_d = '0;
                end
            end

            ST_BURST: begin
                if (slot_free) begin
                    if (fifo_empty) begin
                        // Burst only starts with BURST_LEN entries present, so this means the
                        // FIFO flags were not what this stage was built against.
                        err_underrun_d = 1'b1;
                    end else begin
                        pop      = 1'b1;
                        pop_last = (beat_cnt_q == LAST_BEAT);
                        if (pop_last) begin
                            state_d       = ST_IDLE;
                            beat_cnt_d    = '0;
                            burst_count_d = burst_count_q + 16'd1;
                        end else begin
                            beat_cnt_d = beat_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                if (fifo_empty) begin
                    state_d = ST_IDLE;
                end else if (!fifo_almost_empty) begin
                    // Enough data arrived mid-flush: hand over to a full burst via IDLE.
                    state_d = ST_IDLE;
                end else if (slot_free) begin
                    pop           = 1'b1;
                    pop_last      = 1'b1;
                    burst_count_d = burst_count_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            beat_cnt_q     <= '0;
            idle_timer_q   <= '0;
            burst_count_q  <= '0;
            err_underrun_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            beat_cnt_q     <= beat_cnt_d;
            idle_timer_q   <= idle_timer_d;
            burst_count_q  <= burst_count_d;
            err_underrun_q <= err_underrun_d;
        end
    end

    // Output slot. A pop overwrites the slot even when the old beat is leaving this edge,
    // which gives back-to-back beats without a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
        end else if (pop) begin
            m_data_q  <= fifo_dout;
            m_valid_q <= 1'b1;
            m_last_q  <= pop_last;
        end else if (slot_free) begin
            m_valid_q <= 1'b0;
        end
    end

    assign fifo_rd_en   = pop && !rst;
    assign m_data       = m_data_q;
    assign m_valid      = m_valid_q;
    assign m_last       = m_last_q;
    assign busy         = (state_q != ST_IDLE) || m_valid_q;
    assign burst_count  = burst_count_q;
    assign err_underrun = err_underrun_q;

endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// Bench for sync_fifo_burst_reader: a queue stands in for sync_fifo (show-ahead head, flags from
// occupancy, pushes land right after a clock edge as if written at that edge), a scoreboard
// checks stream order and burst framing, directed scenarios check exact beats and cycles.
module tb_sync_fifo_burst_reader;

    localparam int WIDTH     = 32;
    localparam int BURST_LEN = 8;
    localparam int TIMEOUT   = 16;
    localparam int DEPTH     = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] fifo_dout;
    logic             fifo_empty;
    logic             fifo_almost_empty;
    logic             fifo_rd_en;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_last;
    logic             m_ready;
    logic             busy;
    logic [15:0]      burst_count;
    logic             err_underrun;

    sync_fifo_burst_reader #(
        .WIDTH(WIDTH), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty),
        .fifo_rd_en(fifo_rd_en),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy), .burst_count(burst_count), .err_underrun(err_underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] fq[$];      // FIFO contents
    logic [WIDTH-1:0] exp_q[$];   // scoreboard: everything written, in order
    logic [WIDTH-1:0] acc_dat[$]; // beats accepted downstream in the current scenario
    logic             acc_last[$];
    int               acc_cyc[$];

    int               cyc_n      = 0;
    int               run_len    = 0;
    int               stalls     = 0;
    logic             last_rd    = 1'b0;
    logic             prev_stall = 1'b0;
    logic [WIDTH-1:0] prev_dat   = '0;
    logic             prev_last  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive_fifo();
        fifo_dout         = (fq.size() > 0) ? fq[0] : '0;
        fifo_empty        = (fq.size() == 0);
        fifo_almost_empty = (fq.size() < BURST_LEN);
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        fq.push_back(v);
        exp_q.push_back(v);
        drive_fifo();
    endtask

    // One clock cycle: inputs are set #1 after an edge, outputs sampled at the falling edge.
    task automatic tick(input logic rdy);
        logic             s_rd, s_vld, s_last, s_rst;
        logic [WIDTH-1:0] s_dat;
        m_ready = rdy;
        drive_fifo();
        @(negedge clk);
        s_rd   = fifo_rd_en;
        s_vld  = m_valid;
        s_last = m_last;
        s_dat  = m_data;
        s_rst  = rst;
        check("rd_while_empty", 64'(s_rd & fifo_empty), 64'd0);
        check("rd_in_reset", 64'(s_rd & s_rst), 64'd0);
        check("pop_while_busy", 64'(s_rd & s_vld & ~rdy), 64'd0);
        if (prev_stall && !s_rst) begin
            check("hold_valid", 64'(s_vld), 64'd1);
            check("hold_data", 64'(s_dat), 64'(prev_dat));
            check("hold_last", 64'(s_last), 64'(prev_last));
        end
        @(posedge clk);
        #1;
        cyc_n++;
        last_rd = s_rd;
        if (s_rst) begin
            fq.delete();
            exp_q.delete();
            run_len    = 0;
            prev_stall = 1'b0;
        end else begin
            if (s_rd && fq.size() > 0) void'(fq.pop_front());
            if (s_vld && rdy) begin
                acc_dat.push_back(s_dat);
                acc_last.push_back(s_last);
                acc_cyc.push_back(cyc_n);
                if (exp_q.size() == 0) check("unexpected_beat", 64'd1, 64'd0);
                else check("order", 64'(s_dat), 64'(exp_q.pop_front()));
                run_len++;
                if (s_last) begin
                    check("burst_framing", 64'((run_len == BURST_LEN) || (run_len == 1)), 64'd1);
                    run_len = 0;
                end
            end
            if (s_vld && !rdy) stalls++;
            prev_stall = s_vld && !rdy;
            prev_dat   = s_dat;
            prev_last  = s_last;
        end
        drive_fifo();
    endtask

    task automatic clear_log();
        acc_dat.delete();
        acc_last.delete();
        acc_cyc.delete();
        stalls = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b1);
        rst = 1'b0;
        clear_log();
    endtask

    // Run until the FIFO is empty and the reader is idle; pattern 1 toggles m_ready 1,0,0,1.
    task automatic drain(input int max_cyc, input int pattern);
        logic done;
        logic rdy;
        done = 1'b0;
        for (int k = 0; k < max_cyc && !done; k++) begin
            rdy = 1'b1;
            if (pattern == 1) rdy = ((k % 4) == 0) || ((k % 4) == 3);
            tick(rdy);
            done = (fq.size() == 0) && !busy;
        end
        check("drain_done", 64'(done), 64'd1);
    endtask

    task automatic check_beats(input string tag, input logic [WIDTH-1:0] d[], input logic l[]);
        check({tag, "_count"}, 64'(acc_dat.size()), 64'(d.size()));
        for (int i = 0; i < d.size() && i < acc_dat.size(); i++) begin
            check($sformatf("%s_data[%0d]", tag, i), 64'(acc_dat[i]), 64'(d[i]));
            check($sformatf("%s_last[%0d]", tag, i), 64'(acc_last[i]), 64'(l[i]));
        end
    endtask

    initial begin
        logic [WIDTH-1:0] ed[];
        logic             el[];
        int               c0;
        logic             got;

        rst     = 1'b1;
        m_ready = 1'b0;
        drive_fifo();
        repeat (3) tick(1'b0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_burst_count", 64'(burst_count), 64'd0);
        check("rst_err_underrun", 64'(err_underrun), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        clear_log();

        // Scenario 1: one exact burst 0x10..0x17. Write edge c0: state flips at c0+1,
        // first pop at c0+2, first beat accepted at c0+3, then one per cycle.
        c0 = cyc_n;
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h10 + i));
        drain(200, 0);
        ed = new[8];
        el = new[8];
        for (int i = 0; i < 8; i++) begin
            ed[i] = WIDTH'(32'h10 + i);
            el[i] = (i == 7);
        end
        check_beats("s1", ed, el);
        for (int i = 0; i < 8 && i < acc_cyc.size(); i++)
            check($sformatf("s1_cycle[%0d]", i), 64'(acc_cyc[i] - c0), 64'(3 + i));
        check("s1_burst_count", 64'(burst_count), 64'd1);
        check("s1_fifo_empty", 64'(fq.size()), 64'd0);
        check("s1_busy", 64'(busy), 64'd0);

        // Scenario 2: 20 entries -> 8 + bubble + 8, then 4 single-beat flushes.
        // Burst 2 ends with its last pop at c0+18; IDLE counts edges c0+19..c0+34 (TIMEOUT of
        // them), FLUSH pops c0+35..c0+38, beats accepted c0+36..c0+39.
        do_reset();
        c0 = cyc_n;
        for (int i = 0; i < 20; i++) push(WIDTH'(32'h40 + i));
        drain(400, 0);
        ed = new[20];
        el = new[20];
        for (int i = 0; i < 20; i++) begin
            ed[i] = WIDTH'(32'h40 + i);
            el[i] = (i == 7) || (i == 15) || (i >= 16);
        end
        check_beats("s2", ed, el);
        for (int i = 0; i < 20 && i < acc_cyc.size(); i++)
            check($sformatf("s2_cycle[%0d]", i), 64'(acc_cyc[i] - c0),
                  64'((i < 8) ? 3 + i : (i < 16) ? 4 + i : 20 + TIMEOUT + (i - 16)));
        check("s2_burst_count", 64'(burst_count), 64'd6);

        // Scenario 3: burst under m_ready 1,0,0,1; stalls must hold data/last (checked per cycle).
        do_reset();
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h20 + i));
        drain(400, 1);
        ed = new[8];
        el = new[8];
        for (int i = 0; i < 8; i++) begin
            ed[i] = WIDTH'(32'h20 + i);
            el[i] = (i == 7);
        end
        check_beats("s3", ed, el);
        check("s3_stall_seen", 64'(stalls > 0), 64'd1);
        check("s3_burst_count", 64'(burst_count), 64'd1);

        // Scenario 4: 3-entry flush interrupted by 8 new writes after the first flush pop.
        // Remaining 10 entries: FLUSH -> IDLE -> full burst B,C,N0..N5, then N6, N7 flushed.
        do_reset();
        for (int i = 0; i < 3; i++) push(WIDTH'(32'h30 + i));
        got = 1'b0;
        for (int k = 0; k < 100 && !got; k++) begin
            tick(1'b1);
            got = last_rd;
        end
        check("s4_flush_pop_seen", 64'(got), 64'd1);
        for (int j = 0; j < 8; j++) push(WIDTH'(32'h50 + j));
        drain(400, 0);
        ed = new[11];
        el = new[11];
        ed[0] = 32'h30; el[0] = 1'b1;
        ed[1] = 32'h31; el[1] = 1'b0;
        ed[2] = 32'h32; el[2] = 1'b0;
        for (int j = 0; j < 8; j++) begin
            ed[3 + j] = WIDTH'(32'h50 + j);
            el[3 + j] = (j >= 5);
        end
        check_beats("s4", ed, el);
        check("s4_burst_count", 64'(burst_count), 64'd4);

        // Scenario 5: reset while beat 4 of a burst is in the slot, then a clean burst.
        do_reset();
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h70 + i));
        for (int k = 0; k < 50 && acc_dat.size() < 4; k++) tick(1'b1);
        check("s5_beats_before_rst", 64'(acc_dat.size()), 64'd4);
        check("s5_slot_full_before_rst", 64'(m_valid), 64'd1);
        rst = 1'b1;
        tick(1'b1);
        check("s5_rst_m_valid", 64'(m_valid), 64'd0);
        check("s5_rst_burst_count", 64'(burst_count), 64'd0);
        check("s5_rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        clear_log();
        for (int i = 0; i < 8; i++) push(WIDTH'(32'h60 + i));
        drain(200, 0);
        ed = new[8];
        el = new[8];
        for (int i = 0; i < 8; i++) begin
            ed[i] = WIDTH'(32'h60 + i);
            el[i] = (i == 7);
        end
        check_beats("s5", ed, el);
        check("s5_burst_count", 64'(burst_count), 64'd1);

        // Scenario 6: random writes and m_ready, scoreboard and framing checked per beat.
        do_reset();
        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 99) < 30 && fq.size() < DEPTH) push(WIDTH'($urandom));
            tick($urandom_range(0, 99) < 70);
        end
        drain(2000, 0);
        check("s6_all_delivered", 64'(exp_q.size()), 64'd0);
        check("s6_err_underrun", 64'(err_underrun), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_burst_reader.md
# sync_fifo_burst_reader

Drain stage placed directly downstream of `sync_fifo`. It pops the FIFO's show-ahead read port and sends the data on a registered valid/ready stream as fixed-length bursts framed by `m_last`. Burst starts are gated by the FIFO's `almost_empty` flag. A residue left below one burst is flushed as single-beat bursts after an idle timeout.

## Interface
- `WIDTH`, 32, data width; must equal the FIFO `WIDTH`.
- `BURST_LEN`, 8, beats per full burst; must be ≥2. The FIFO must be built with `EMPTY_THRESHOLD = BURST_LEN-1`, so `!almost_empty` means at least BURST_LEN entries.
- `TIMEOUT`, 64, idle cycles before a residue flush; must be ≥1.
- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `fifo_dout`  in  WIDTH  FIFO head entry; valid whenever `!fifo_empty`.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_almost_empty`  in  1  FIFO almost-empty flag.
- `fifo_rd_en`  out  1  pop strobe (combinational); the head is consumed at this edge.
- `m_data`  out  WIDTH  stream data (registered).
- `m_valid`  out  1  stream valid (registered).
- `m_last`  out  1  final beat of a burst.
- `m_ready`  in  1  downstream accept.
- `busy`  out  1  high when state ≠ IDLE or `m_valid`.
- `burst_count`  out  16  number of bursts sent; wraps at 16 bits.
- `err_underrun`  out  1  sticky error: a pop was needed while `fifo_empty` was high.

## Operation
- State machine: IDLE, BURST, FLUSH. Internal counters:
  - `beat_cnt`, `$clog2(BURST_LEN)` bits.
  - `idle_timer`, `$clog2(TIMEOUT+1)` bits.
- Output slot: one register holding `m_data`/`m_valid`/`m_last`.
  - The slot is free when `!m_valid || m_ready`.
  - Pop condition: pop ⇔ pop-eligible state && `!fifo_empty` && slot free.
  - On pop: `fifo_dout` is loaded into `m_data` and `m_valid` is set to 1 at the same edge.
  - When the slot is free and no pop occurs, `m_valid` goes to 0.
- IDLE:
  - `!fifo_almost_empty` → go to BURST and clear `beat_cnt` and `idle_timer`.
  - Otherwise, `!fifo_empty` → increment `idle_timer`. When it reaches TIMEOUT-1, go to FLUSH and clear the timer.
  - Otherwise (`fifo_empty`) → clear `idle_timer`.
  - No pops occur in IDLE.
- BURST:
  - Pop whenever the slot is free. `m_last` = (`beat_cnt`==BURST_LEN-1).
  - Each pop increments `beat_cnt`.
  - The last pop returns the FSM to IDLE and increments `burst_count`.
  - Slot busy with `!m_ready` → stall, holding state and counters.
  - `fifo_empty` while the slot is free → set `err_underrun`, do not pop, stay in BURST. This cannot happen while the FIFO occupancy reasoning holds.
- FLUSH, evaluated in priority order:
  1. `fifo_empty` → go to IDLE.
  2. `!fifo_almost_empty` → go to IDLE with no pop; the next cycle starts a BURST.
  3. Slot free → pop one beat with `m_last=1`, increment `burst_count`, stay in FLUSH.
- `m_data`/`m_last` stay stable while `m_valid && !m_ready`.
- Beats are never dropped or reordered. `fifo_rd_en` is never high while `fifo_empty` is high.

## Timing
- Reset values:
  - State IDLE; counters 0.
  - `m_valid`=0, `m_data`=0, `m_last`=0, `burst_count`=0, `err_underrun`=0, `busy`=0.
  - `fifo_rd_en`=0 during `rst`.
- Reset mid-burst: any beat held in the slot is discarded and `beat_cnt` is cleared. The FIFO is reset by the same `rst`.
- Burst start latency:
  - `!fifo_almost_empty` sampled in IDLE at edge t.
  - First `fifo_rd_en` in cycle t+1.
  - First `m_valid` after edge t+2.
- Throughput with `m_ready` held high:
  - One beat per cycle within a burst.
  - One idle cycle between back-to-back bursts (IDLE re-evaluates).
- Flush latency: residue present and `almost_empty` held for TIMEOUT cycles in IDLE → FLUSH → first pop the next cycle.
- Simultaneous pop and `m_ready`: the old beat is accepted and the new beat loaded at the same edge, with no bubble.

## Test plan
- BURST_LEN=8, 8 entries written (0x10..0x17), `m_ready`=1 → one burst 0x10..0x17, `m_last` only on 0x17. Afterwards `burst_count`=1 and `fifo_empty`=1.
- 20 entries present, `m_ready`=1 → two 8-beat bursts with one bubble between them. The remaining 4 entries flush as four single-beat bursts (`m_last`=1) TIMEOUT cycles after the second burst. Final `burst_count`=6.
- Burst in progress, `m_ready` toggling 1,0,0,1 → `m_data`/`m_last` held during stalls, no pops while the slot is busy, order intact.
- 3 entries in FLUSH, then 8 more written before the second flush pop → FLUSH exits to IDLE, and a full 8-beat burst follows. The flush sequencing of the remaining residue is checked against the FLUSH rules above.
- `rst` asserted on beat 4 of a burst → next cycle `m_valid`=0, `burst_count`=0, `busy`=0. After reset, a fresh 8-entry fill yields a normal burst.
- Random writes and `m_ready` over 10k cycles → scoreboard matches FIFO order exactly, every burst is BURST_LEN beats or a single flush beat, `err_underrun` stays 0.
